bin_to_bcd_display: RTL and testbench
=====================================

Name: bin_to_bcd_display

Overview:
Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits plus leading-zero blank flags. Its outputs connect directly to the BCH and blank inputs of the seven-segment display path. Typical use is showing a note number, velocity or frequency on the HEX displays. Conversion runs one bit per clock behind a start/done handshake, and the outputs hold stable between conversions.

Parameters:
BIN_WIDTH, 16, width of the unsigned binary input (>= 1)
DIGITS, 8, number of BCD digits produced (>= 1); the result is value mod 10^DIGITS, and overflow is flagged if digits are lost

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion; sampled only in IDLE
bin  input  BIN_WIDTH  binary value; captured on the accepting edge
busy  output  1  high while a conversion is in progress (SHIFT or LOAD)
done  output  1  single-cycle pulse when new results become visible
bcd  output  4*DIGITS  packed digits; digit i is bcd[4i+3:4i], digit 0 is least significant
blank  output  DIGITS  blank[i]=1 means digit i is a suppressed leading zero
overflow  output  1  result needed more than DIGITS digits; held with bcd

Behaviour:
- Reset (synchronous, active-high): applies on the next clock edge.
  - State goes to IDLE and all scratch registers clear.
  - bcd=0, blank = all ones except blank[0]=0 (the display shows "0"), overflow=0, busy=0, done=0.
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - On an edge with start=1: capture bin into the shift register, clear the BCD scratch and the sticky overflow, set bit counter = BIN_WIDTH, go to SHIFT.
  - busy becomes 1 at that same edge.
- SHIFT, one step per cycle:
  - Every scratch digit >= 5 gets +3 (combinational, all digits in parallel).
  - Then shift {scratch, binreg} left by one.
  - If the bit shifted out of the top digit is 1, set sticky overflow.
  - Decrement the counter. On the edge where the counter goes 1 -> 0, go to LOAD.
  - The SHIFT state therefore lasts exactly BIN_WIDTH cycles.
- LOAD:
  - Copy scratch into bcd, the sticky flag into overflow, and the computed blank into blank.
  - Assert done for exactly that one cycle, then return to IDLE.
- Blank computation:
  - blank[i]=1 iff digit i and every higher digit are zero, for i>=1.
  - blank[0] is always 0.
  - When overflow=1, blank is all zeros (every digit is shown).
- Latency and output timing:
  - If start is accepted at edge k, bcd/blank/overflow change and done=1 in the cycle following edge k+BIN_WIDTH+1.
  - busy is high for BIN_WIDTH+1 cycles.
- Output stability: bcd, blank and overflow change only in LOAD or on reset, never mid-conversion.
- start while busy is ignored and not queued. start asserted in the done cycle is accepted, which gives back-to-back conversions every BIN_WIDTH+2 cycles.
- bin is don't-care except on the accepting edge.
- Reset mid-conversion: the conversion is abandoned, outputs go to their reset values, and done does not pulse.
- Arithmetic:
  - The add-3 operates on 4-bit digits; after adjustment a digit never exceeds 4'd12, so no carry leaves a digit.
  - The scratch register is 4*DIGITS bits wide.
  - Digits not lost to overflow equal the exact decimal digits of bin mod 10^DIGITS.

Decomposition:
- Shared package (display_pkg):
  - typedef for the state enum {IDLE, SHIFT, LOAD};
  - typedef for the 4-bit BCD digit;
  - constants for the default BIN_WIDTH and DIGITS;
  - constant ADD3_THRESHOLD=5.
- One natural sub-module: bcd_digit_adjust, a purely combinational 4-bit "if >=5 add 3" unit, instantiated DIGITS times with a generate loop.
- The counter width is $clog2(BIN_WIDTH+1).

Test Plan:
- Zero (BIN_WIDTH=16, DIGITS=8): start with bin=0 -> done pulse at k+17; bcd=32'h0000_0000; blank=8'hFE; overflow=0.
- Typical value: bin=12345 -> bcd=32'h0001_2345; blank=8'hE0; busy high exactly 17 cycles; done high exactly 1 cycle.
- Full scale: bin=16'hFFFF -> bcd=32'h0006_5535, blank=8'hE0. Then start in the done cycle with bin=9 -> second result bcd=32'h0000_0009, blank=8'hFE, 18 cycles after the first acceptance.
- Busy/stability: start a conversion of 500 with the previous result 42 on display. Pulse start with bin=777 at k+5 -> that start is ignored, bcd stays 32'h42 until LOAD, then becomes 32'h500, blank=8'hF8.
- Overflow (DIGITS=4, BIN_WIDTH=16): bin=12345 -> bcd=16'h2345, overflow=1, blank=4'h0. A following bin=9999 -> overflow=0, bcd=16'h9999.
- Reset mid-conversion: assert reset at k+8 while converting 12345 -> the next cycle shows bcd=0, blank=8'hFE, busy=0, and no done pulse. A subsequent start with bin=321 converts normally to 32'h321.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the binary-to-BCD display path
package display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  typedef logic [3:0] digit_t;
  localparam int BIN_WIDTH_DEF = 16;
  localparam int DIGITS_DEF = 8;
  localparam digit_t ADD3_THRESHOLD = 4'd5;
endpackage

// File: rtl/bin_to_bcd_display_if.sv
// bin_to_bcd_display_if: start/done handshake plus BCD result bus
interface bin_to_bcd_display_if #(
  parameter int BIN_WIDTH = display_pkg::BIN_WIDTH_DEF,
  parameter int DIGITS = display_pkg::DIGITS_DEF
);
  logic start;
  logic [BIN_WIDTH-1:0] bin;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0] blank;
  logic overflow;
  modport master (output start, bin, input busy, done, bcd, blank, overflow);
  modport slave (input start, bin, output busy, done, bcd, blank, overflow);
endinterface

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble "if >= 5 add 3" correction for one BCD digit
module bcd_digit_adjust
  import display_pkg::*;
(
  input  digit_t d,
  output digit_t q
);
  assign q = d >= ADD3_THRESHOLD ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: sequential double-dabble converter with leading-zero blanking
module bin_to_bcd_display
  import display_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input logic clock,
  input logic reset,
  bin_to_bcd_display_if.slave bus
);
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int SW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  state_t state, state_n;
  logic [BIN_WIDTH-1:0] binreg;
  logic [SW-1:0] scratch, adj;
  logic [CW-1:0] cnt;
  logic sticky;
  logic z;
  logic [DIGITS-1:0] blank_n;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (.d(scratch[4*i+:4]), .q(adj[4*i+:4]));
  end
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE  ? (bus.start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(1) ? LOAD : SHIFT) : IDLE;
  end
  // a digit blanks only if it and every digit above it are zero
  always_comb begin
    z = 1'b1;
    blank_n = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (scratch[4*i+:4] == 4'd0);
      blank_n[i] = z & ~sticky;
    end
    blank_n[0] = 1'b0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      binreg <= '0;
      scratch <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      bus.bcd <= '0;
      bus.blank <= BLANK_RST;
      bus.overflow <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      bus.done <= state == LOAD;
      if (state == IDLE && bus.start) begin
        binreg <= bus.bin;
        scratch <= '0;
        sticky <= 1'b0;
        cnt <= CW'(BIN_WIDTH);
      end else if (state == SHIFT) begin
        {scratch, binreg} <= {adj[SW-2:0], binreg, 1'b0};
        sticky <= sticky | adj[SW-1];
        cnt <= cnt - 1'b1;
      end else if (state == LOAD) begin
        bus.bcd <= scratch;
        bus.blank <= blank_n;
        bus.overflow <= sticky;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb_bin_to_bcd_display: scoreboard bench for 8-digit and 4-digit converters
module tb_bin_to_bcd_display;
  typedef struct {logic [31:0] bcd; logic [7:0] blank; logic ovf;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t q8[$];
  exp_t q4[$];
  always #5 clock = ~clock;
  bin_to_bcd_display_if #(.BIN_WIDTH(16), .DIGITS(8)) if8();
  bin_to_bcd_display_if #(.BIN_WIDTH(16), .DIGITS(4)) if4();
  bin_to_bcd_display #(.BIN_WIDTH(16), .DIGITS(8)) dut8 (.clock(clock), .reset(reset), .bus(if8));
  bin_to_bcd_display #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (.clock(clock), .reset(reset), .bus(if4));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clock) if (if8.done) begin
    exp_t e;
    if (q8.size() == 0) chk("unexpected_done8", 1, 0);
    else begin
      e = q8.pop_front();
      chk("bcd8", if8.bcd, e.bcd);
      chk("blank8", 32'(if8.blank), 32'(e.blank));
      chk("ovf8", 32'(if8.overflow), 32'(e.ovf));
    end
  end
  always @(negedge clock) if (if4.done) begin
    exp_t e;
    if (q4.size() == 0) chk("unexpected_done4", 1, 0);
    else begin
      e = q4.pop_front();
      chk("bcd4", 32'(if4.bcd), e.bcd);
      chk("blank4", 32'(if4.blank), 32'(e.blank));
      chk("ovf4", 32'(if4.overflow), 32'(e.ovf));
    end
  end
  task automatic go(int sel, logic [15:0] v, exp_t e);
    if (sel != 0) begin
      q4.push_back(e);
      if4.start = 1'b1;
      if4.bin = v;
    end else begin
      q8.push_back(e);
      if8.start = 1'b1;
      if8.bin = v;
    end
    @(posedge clock);
    #1;
    if4.start = 1'b0;
    if8.start = 1'b0;
  endtask
  task automatic wait_done(int sel, int lat, logic [31:0] prev);
    int n = 0;
    int b = 0;
    logic d;
    do begin
      @(negedge clock);
      n++;
      d = sel != 0 ? if4.done : if8.done;
      b += int'(sel != 0 ? if4.busy : if8.busy);
      if (!d) chk("stable_bcd", sel != 0 ? 32'(if4.bcd) : if8.bcd, prev);
    end while (!d && n < 40);
    chk("latency", n, lat);
    chk("busy_cycles", b, lat - 1);
  endtask
  initial begin
    if8.start = 1'b0;
    if8.bin = '0;
    if4.start = 1'b0;
    if4.bin = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_bcd", if8.bcd, 0);
    chk("rst_blank", 32'(if8.blank), 32'h FE);
    chk("rst_busy", 32'(if8.busy), 0);
    chk("rst_done", 32'(if8.done), 0);
    chk("rst_ovf", 32'(if8.overflow), 0);
    chk("rst_blank4", 32'(if4.blank), 32'h E);
    @(posedge clock); #1;
    go(0, 16'd0, '{32'h0, 8'hFE, 1'b0});
    wait_done(0, 18, 32'h0);
    @(posedge clock); #1;
    go(0, 16'd12345, '{32'h12345, 8'hE0, 1'b0});
    wait_done(0, 18, 32'h0);
    @(posedge clock); #1;
    go(0, 16'hFFFF, '{32'h65535, 8'hE0, 1'b0});
    wait_done(0, 18, 32'h12345);
    go(0, 16'd9, '{32'h9, 8'hFE, 1'b0});
    wait_done(0, 18, 32'h65535);
    @(posedge clock); #1;
    go(0, 16'd42, '{32'h42, 8'hFC, 1'b0});
    wait_done(0, 18, 32'h9);
    @(posedge clock); #1;
    go(0, 16'd500, '{32'h500, 8'hF8, 1'b0});
    fork
      wait_done(0, 18, 32'h42);
      begin
        repeat (4) @(posedge clock);
        #1 if8.start = 1'b1;
        if8.bin = 16'd777;
        @(posedge clock);
        #1 if8.start = 1'b0;
      end
    join
    repeat (25) @(posedge clock);
    #1 chk("hold_after_ignore", if8.bcd, 32'h500);
    go(0, 16'd12345, '{32'h12345, 8'hE0, 1'b0});
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    void'(q8.pop_back());
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_bcd", if8.bcd, 0);
    chk("abort_blank", 32'(if8.blank), 32'h FE);
    chk("abort_busy", 32'(if8.busy), 0);
    chk("abort_done", 32'(if8.done), 0);
    repeat (25) @(posedge clock);
    #1;
    go(0, 16'd321, '{32'h321, 8'hF8, 1'b0});
    wait_done(0, 18, 32'h0);
    @(posedge clock); #1;
    go(1, 16'd12345, '{32'h2345, 8'h0, 1'b1});
    wait_done(1, 18, 32'h0);
    @(posedge clock); #1;
    go(1, 16'd9999, '{32'h9999, 8'h0, 1'b0});
    wait_done(1, 18, 32'h2345);
    repeat (3) @(posedge clock);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
